// File: rtl/mdu_ctrl_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
// master: EX/decode side; slave: mdu_ctrl (busy, stall, HI, LO).
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, md_op, A, B, d_is_md,
    input  busy, stall, HI, LO
  );

  modport slave (
    input  start, md_op, A, B, d_is_md,
    output busy, stall, HI, LO
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div unit owning HI/LO; models latency and drives D stall.
// Ports: clk, reset (sync, active-high), bus (mdu_ctrl_if.slave).
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES - 1);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;

  logic        start_arith;
  logic        is_mul;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] qu;
  logic [31:0] ru;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic        wr;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign start_arith = bus.start &
    (bus.md_op >= OP_MULT) & (bus.md_op <= OP_DIVU);
  assign is_mul = (bus.md_op == OP_MULT) |
    (bus.md_op == OP_MULTU);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) *
    $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes: 0x80000000 / -1 then
  // wraps to 0x80000000 with remainder 0 naturally.
  assign a_mag = a_q[31] ? -a_q : a_q;
  assign b_mag = b_q[31] ? -b_q : b_q;
  assign dvd = (op_q == OP_DIV) ? a_mag : a_q;
  assign dvs = (op_q == OP_DIV) ? b_mag : b_q;
  // Divisor forced nonzero; the result is dropped anyway.
  assign qu = dvd / ((dvs == 32'd0) ? 32'd1 : dvs);
  assign ru = dvd % ((dvs == 32'd0) ? 32'd1 : dvs);
  assign q_s = (a_q[31] ^ b_q[31]) ? -qu : qu;
  assign r_s = a_q[31] ? -ru : ru;

  always_comb begin
    wr     = 1'b0;
    res_hi = hi_q;
    res_lo = lo_q;
    unique case (1'b1)
      op_q == OP_MULT: begin
        wr     = 1'b1;
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      op_q == OP_MULTU: begin
        wr     = 1'b1;
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      op_q == OP_DIV: begin
        wr     = (b_q != 32'd0);
        res_hi = r_s;
        res_lo = q_s;
      end
      op_q == OP_DIVU: begin
        wr     = (b_q != 32'd0);
        res_hi = ru;
        res_lo = qu;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      cnt    <= 4'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      op_q   <= 3'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_arith) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            op_q   <= bus.md_op;
            cnt    <= is_mul ? MULT_N : DIV_N;
            busy_q <= 1'b1;
            state  <= RUN;
          end else if (bus.start &&
                       bus.md_op == OP_MTHI) begin
            hi_q <= bus.A;
          end else if (bus.start &&
                       bus.md_op == OP_MTLO) begin
            lo_q <= bus.A;
          end
        end
        default: begin
          if (cnt == 4'd0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;
  assign bus.stall = bus.d_is_md & (busy_q | start_arith);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of HI/LO results
// popped when busy falls, plus per-scenario timing checks.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mdu_ctrl_if m();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk),
    .reset(reset),
    .bus(m)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic busy_d = 1'b0;

  always @(negedge clk) begin
    res_t r;
    if (reset) begin
      busy_d = 1'b0;
    end else begin
      if (busy_d && !m.busy && sb.size() > 0) begin
        r = sb.pop_front();
        checks++;
        if (m.HI !== r.hi || m.LO !== r.lo) begin
          errors++;
          $display("FAIL sb_result: HI=%h LO=%h want HI=%h LO=%h",
                   m.HI, m.LO, r.hi, r.lo);
        end
      end
      busy_d = m.busy;
    end
  end

  task automatic expect_op(input logic [2:0] op,
                           input logic [31:0] a,
                           input logic [31:0] b);
    res_t r;
    longint sa;
    longint sv;
    logic [63:0] p;
    sa = longint'($signed(a));
    sv = longint'($signed(b));
    r.hi = m_hi;
    r.lo = m_lo;
    case (op)
      3'd1: begin
        p = sa * sv;
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        r.hi = p[63:32];
        r.lo = p[31:0];
      end
      3'd3: if (b != 0) begin
        r.lo = 32'(sa / sv);
        r.hi = 32'(sa % sv);
      end
      3'd4: if (b != 0) begin
        r.lo = a / b;
        r.hi = a % b;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
    if (op >= 3'd1 && op <= 3'd4) begin
      sb.push_back(r);
      m_hi = r.hi;
      m_lo = r.lo;
    end
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    expect_op(op, a, b);
    m.start = 1'b1;
    m.md_op = op;
    m.A = a;
    m.B = b;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.md_op = 3'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (m.busy && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    m.start = 1'b0;
    m.md_op = 3'd0;
    m.A = 32'd0;
    m.B = 32'd0;
    m.d_is_md = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if (m.busy !== 1'b0 || m.HI !== 32'd0 || m.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b HI=%h LO=%h want 0 0 0",
               m.busy, m.HI, m.LO);
    end
    m.d_is_md = 1'b1;
    #1;
    checks++;
    if (m.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_idle: stall=%b want 0", m.stall);
    end
    m.start = 1'b1;
    m.md_op = 3'd3;
    #1;
    checks++;
    if (m.stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_start_comb: stall=%b want 1", m.stall);
    end
    m.md_op = 3'd5;
    #1;
    checks++;
    if (m.stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_mthi: stall=%b want 0", m.stall);
    end
    m.start = 1'b0;
    m.md_op = 3'd0;
    m.d_is_md = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL mult_busy: cycles=%0d want 5", n);
    end
    checks++;
    if (m.HI !== 32'hFFFFFFFF || m.LO !== 32'hFFFFFFFA) begin
      errors++;
      $display("FAIL mult_val: HI=%h LO=%h want ffffffff fffffffa",
               m.HI, m.LO);
    end
    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    checks++;
    if (n != 5 || m.HI !== 32'hFFFFFFFE || m.LO !== 32'h1) begin
      errors++;
      $display("FAIL multu: n=%0d HI=%h LO=%h want 5 fffffffe 1",
               n, m.HI, m.LO);
    end
  endtask

  task automatic test_div;
    int n;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL div_busy: cycles=%0d want 10", n);
    end
    checks++;
    if (m.HI !== 32'hFFFFFFFF || m.LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_val: HI=%h LO=%h want ffffffff fffffffd",
               m.HI, m.LO);
    end
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    checks++;
    if (m.HI !== 32'h0 || m.LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf: HI=%h LO=%h want 0 80000000",
               m.HI, m.LO);
    end
    issue(3'd4, 32'd100, 32'd7);
    wait_idle(n);
    checks++;
    if (m.HI !== 32'd2 || m.LO !== 32'd14) begin
      errors++;
      $display("FAIL divu: HI=%h LO=%h want 2 e", m.HI, m.LO);
    end
    issue(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    checks++;
    if (n != 10 || m.HI !== 32'd2 || m.LO !== 32'd14) begin
      errors++;
      $display("FAIL div_zero: n=%0d HI=%h LO=%h want 10 2 e",
               n, m.HI, m.LO);
    end
  endtask

  task automatic test_mthi_mtlo;
    issue(3'd5, 32'h12345678, 32'd0);
    checks++;
    if (m.HI !== 32'h12345678 || m.LO !== 32'd14 || m.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: HI=%h LO=%h busy=%b want 12345678 e 0",
               m.HI, m.LO, m.busy);
    end
    issue(3'd6, 32'h9ABCDEF0, 32'd0);
    checks++;
    if (m.LO !== 32'h9ABCDEF0 || m.HI !== 32'h12345678 || m.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h busy=%b want 12345678 9abcdef0 0",
               m.HI, m.LO, m.busy);
    end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    expect_op(3'd1, 32'd5, 32'd6);
    m.d_is_md = 1'b1;
    m.start = 1'b1;
    m.md_op = 3'd1;
    m.A = 32'd5;
    m.B = 32'd6;
    #1;
    checks++;
    if (m.stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_start: stall=%b want 1", m.stall);
    end
    @(posedge clk); #1;
    m.start = 1'b0;
    m.md_op = 3'd0;
    n = 0;
    bad = 0;
    while (m.busy && n < 20) begin
      n++;
      if (m.stall !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 5 || bad != 0) begin
      errors++;
      $display("FAIL stall_busy: cycles=%0d low=%0d want 5 0", n, bad);
    end
    checks++;
    if (m.stall !== 1'b0 || m.LO !== 32'd30) begin
      errors++;
      $display("FAIL stall_release: stall=%b LO=%h want 0 1e",
               m.stall, m.LO);
    end
    m.d_is_md = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    issue(3'd3, 32'd100, 32'd3);
    repeat (3) begin
      @(posedge clk); #1;
    end
    sb.delete();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    checks++;
    if (m.busy !== 1'b0 || m.HI !== 32'd0 || m.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b HI=%h LO=%h want 0 0 0",
               m.busy, m.HI, m.LO);
    end
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (m.busy !== 1'b0 || m.HI !== 32'd0 || m.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_discard: busy=%b HI=%h LO=%h want 0 0 0",
               m.busy, m.HI, m.LO);
    end
  endtask

  task automatic test_ignore_mid_run;
    int n;
    issue(3'd1, 32'd7, 32'd9);
    @(posedge clk); #1;
    m.start = 1'b1;
    m.md_op = 3'd4;
    m.A = 32'd1000;
    m.B = 32'd10;
    @(posedge clk); #1;
    m.md_op = 3'd5;
    m.A = 32'hDEADBEEF;
    @(posedge clk); #1;
    m.start = 1'b0;
    m.md_op = 3'd0;
    checks++;
    if (m.HI !== 32'd0 || m.LO !== 32'd0 || m.busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_mid: HI=%h LO=%h busy=%b want 0 0 1",
               m.HI, m.LO, m.busy);
    end
    wait_idle(n);
    checks++;
    if (n != 2 || m.HI !== 32'd0 || m.LO !== 32'd63) begin
      errors++;
      $display("FAIL ignore_done: n=%0d HI=%h LO=%h want 2 0 3f",
               n, m.HI, m.LO);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd1, 32'd3, 32'd4);
    wait_idle(n);
    checks++;
    if (n != 5 || m.LO !== 32'd12) begin
      errors++;
      $display("FAIL b2b_first: n=%0d LO=%h want 5 c", n, m.LO);
    end
    issue(3'd2, 32'd10, 32'd20);
    checks++;
    if (m.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b want 1", m.busy);
    end
    wait_idle(n);
    checks++;
    if (n != 5 || m.HI !== 32'd0 || m.LO !== 32'd200) begin
      errors++;
      $display("FAIL b2b_second: n=%0d HI=%h LO=%h want 5 0 c8",
               n, m.HI, m.LO);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_stall();
    test_reset_mid_run();
    test_ignore_mid_run();
    test_back_to_back();
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: pending=%0d want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
